// File: rtl/speedy_dec_iter.sv
// Iterative Speedy-6-192 decryption: one inverse round per cycle.
// The key is first rolled forward to rk6 through PB, then walked back
// with PBinv while the rounds are peeled off in reverse order.
module speedy_dec_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [191:0] ct,
  input  logic [191:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [191:0] pt,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, KEY, LAST, ROUND, DONE} state_t;

  // Fractional hex digits of pi; string bit 0 is bit 959 here.
  localparam logic [959:0] PI_FRAC = {
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344, 32'hA4093822,
    32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89, 32'h452821E6, 32'h38D01377,
    32'hBE5466CF, 32'h34E90C6C, 32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5,
    32'hB5470917, 32'h9216D5D9, 32'h8979FB1B, 32'hD1310BA6, 32'h98DFB5AC,
    32'h2FFD72DB, 32'hD01ADFB7, 32'hB8E1AFED, 32'h6A267E96, 32'hBA7C9045,
    32'hF12C7F99, 32'h24A19947, 32'hB3916CF7, 32'h0801F2E2, 32'h858EFC16
  };

  // Row offsets of the forward MixColumns circulant.
  localparam int unsigned MC_OFF [0:6] = '{0, 1, 5, 9, 15, 21, 26};

  state_t       state, state_nxt;
  logic [2:0]   cnt;
  logic [191:0] st, rkreg;
  logic [191:0] rk_fwd, rk_back, last_out, round_out;

  // Inner function of the two-round Feistel S-box on 3-bit halves.
  function automatic logic [2:0] sb_f(input logic [2:0] r);
    return {r[0] ^ (r[2] & r[1]), r[2] ^ (r[1] | r[0]), r[1] ^ (r[2] & ~r[0])};
  endfunction

  // Forward S-box is {u,v}^2b with u=L^f(R), v=R^f(u); undo it in reverse.
  function automatic logic [5:0] inv_sbox(input logic [5:0] y);
    logic [5:0] t;
    logic [2:0] l, r;
    t = y ^ 6'h2b;
    r = t[2:0] ^ sb_f(t[5:3]);
    l = t[5:3] ^ sb_f(r);
    return {l, r};
  endfunction

  function automatic logic [191:0] inv_sb(input logic [191:0] x);
    logic [191:0] y;
    y = '0;
    for (int unsigned i = 0; i < 32; i++) y[6*i +: 6] = inv_sbox(x[6*i +: 6]);
    return y;
  endfunction

  // Forward ShiftColumns rotates column j up by j rows; rotate back down.
  function automatic logic [191:0] inv_sc(input logic [191:0] x);
    logic [191:0] y;
    y = '0;
    for (int unsigned i = 0; i < 32; i++)
      for (int unsigned j = 0; j < 6; j++)
        y[6*i + j] = x[6*((i + 32 - j) % 32) + j];
    return y;
  endfunction

  // Circulant p(T^s) applied per column, T being a one-row rotation.
  function automatic logic [191:0] mix(input logic [191:0] x, input int unsigned s);
    logic [191:0] y;
    y = '0;
    for (int unsigned i = 0; i < 32; i++)
      for (int unsigned j = 0; j < 6; j++)
        for (int unsigned o = 0; o < 7; o++)
          y[6*i + j] = y[6*i + j] ^ x[6*((i + MC_OFF[o]*s) % 32) + j];
    return y;
  endfunction

  // p(T)^32 = p(T^32) = I in characteristic 2, so the inverse is p^31,
  // i.e. the product of p(T^s) for s = 1,2,4,8,16.
  function automatic logic [191:0] inv_mc(input logic [191:0] x);
    return mix(mix(mix(mix(mix(x, 1), 2), 4), 8), 16);
  endfunction

  function automatic logic [191:0] inv_half(input logic [191:0] x);
    return inv_sb(inv_sc(inv_sb(inv_sc(x))));
  endfunction

  // PB moves key bit j to position (7j+1) mod 192.
  function automatic logic [191:0] pb(input logic [191:0] x);
    logic [191:0] y;
    y = '0;
    for (int unsigned j = 0; j < 192; j++) y[(7*j + 1) % 192] = x[j];
    return y;
  endfunction

  function automatic logic [191:0] pb_inv(input logic [191:0] x);
    logic [191:0] y;
    y = '0;
    for (int unsigned j = 0; j < 192; j++) y[j] = x[(7*j + 1) % 192];
    return y;
  endfunction

  // Round constant r: key bit j pairs with pi string bit 192r+j.
  function automatic logic [191:0] rc(input logic [2:0] r);
    logic [191:0] y;
    int unsigned  base;
    y    = '0;
    base = 192 * 32'(r);
    if (r < 3'd5)
      for (int unsigned j = 0; j < 192; j++) y[j] = PI_FRAC[959 - base - j];
    return y;
  endfunction

  // Combinational round datapath shared by LAST and ROUND.
  always_comb begin
    rk_fwd    = pb(rkreg);
    rk_back   = pb_inv(rkreg);
    last_out  = inv_half(st ^ rkreg);
    round_out = inv_half(inv_mc(st ^ rkreg ^ rc(cnt)));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = KEY;
      end
      KEY:     if (cnt == 3'd5) state_nxt = LAST;
      LAST:    state_nxt = ROUND;
      ROUND:   if (cnt == 3'd0) state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers; the final whitening is folded into the last
  // ROUND edge so the result appears on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      st        <= '0;
      rkreg     <= '0;
      pt        <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          st    <= ct;
          rkreg <= key;
          cnt   <= '0;
        end
        KEY: begin
          rkreg <= rk_fwd;
          cnt   <= cnt + 3'd1;
        end
        LAST: begin
          st    <= last_out;
          rkreg <= rk_back;
          cnt   <= 3'd4;
        end
        ROUND: begin
          st    <= round_out;
          rkreg <= rk_back;
          if (cnt == 3'd0) begin
            pt        <= round_out ^ rk_back;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_speedy_dec_iter.sv
// Directed and random checks of speedy_dec_iter against a forward
// Speedy-6-192 encryption model.
module tb_speedy_dec_iter;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [191:0] ct, key, pt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  localparam logic [959:0] PI = {
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344, 32'hA4093822,
    32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89, 32'h452821E6, 32'h38D01377,
    32'hBE5466CF, 32'h34E90C6C, 32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5,
    32'hB5470917, 32'h9216D5D9, 32'h8979FB1B, 32'hD1310BA6, 32'h98DFB5AC,
    32'h2FFD72DB, 32'hD01ADFB7, 32'hB8E1AFED, 32'h6A267E96, 32'hBA7C9045,
    32'hF12C7F99, 32'h24A19947, 32'hB3916CF7, 32'h0801F2E2, 32'h858EFC16
  };

  typedef struct {
    logic [191:0] key;
    logic [191:0] pt;
  } vec_t;

  vec_t vecs [6];

  speedy_dec_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ct(ct), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .pt(pt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used for accept spacing.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // ---------------- forward model ----------------
  function automatic logic [2:0] f3(input logic [2:0] r);
    return {r[0] ^ (r[2] & r[1]), r[2] ^ (r[1] | r[0]), r[1] ^ (r[2] & ~r[0])};
  endfunction

  function automatic logic [5:0] sbox(input logic [5:0] x);
    logic [2:0] u, v;
    u = x[5:3] ^ f3(x[2:0]);
    v = x[2:0] ^ f3(u);
    return {u, v} ^ 6'h2b;
  endfunction

  function automatic logic [191:0] m_sb(input logic [191:0] x);
    logic [191:0] y;
    for (int i = 0; i < 32; i++) y[6*i +: 6] = sbox(x[6*i +: 6]);
    return y;
  endfunction

  function automatic logic [191:0] m_sc(input logic [191:0] x);
    logic [191:0] y;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 6; j++)
        y[6*i + j] = x[6*((i + j) % 32) + j];
    return y;
  endfunction

  function automatic logic [191:0] m_mc(input logic [191:0] x);
    logic [191:0] y;
    int off [7];
    off = '{0, 1, 5, 9, 15, 21, 26};
    y = '0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 6; j++)
        for (int o = 0; o < 7; o++)
          y[6*i + j] ^= x[6*((i + off[o]) % 32) + j];
    return y;
  endfunction

  function automatic logic [191:0] m_pb(input logic [191:0] x);
    logic [191:0] y;
    for (int j = 0; j < 192; j++) y[(7*j + 1) % 192] = x[j];
    return y;
  endfunction

  function automatic logic [191:0] m_rc(input int r);
    logic [191:0] y;
    for (int j = 0; j < 192; j++) y[j] = PI[959 - (192*r + j)];
    return y;
  endfunction

  function automatic logic [191:0] encrypt(input logic [191:0] p, input logic [191:0] k);
    logic [191:0] x, rk;
    rk = k;
    x  = p ^ rk;
    for (int r = 0; r < 5; r++) begin
      x  = m_mc(m_sc(m_sb(m_sc(m_sb(x)))));
      rk = m_pb(rk);
      x  = x ^ rk ^ m_rc(r);
    end
    x  = m_sc(m_sb(m_sc(m_sb(x))));
    rk = m_pb(rk);
    return x ^ rk;
  endfunction

  function automatic logic [191:0] rnd192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Must be entered at a negedge; leaves at the negedge after the handshake.
  task automatic run_block(input logic [191:0] p, input logic [191:0] k,
                           input int hold, input bit noise, output int acc);
    int n;
    logic ok;
    logic [191:0] held;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready before accept", 192'(in_ready), 192'd1);
    ct       = encrypt(p, k);
    key      = k;
    in_valid = 1'b1;
    acc      = cyc;
    @(negedge clk);
    in_valid = noise;
    n  = 1;
    ok = 1'b1;
    while (!out_valid && n < 40) begin
      if (!busy) ok = 1'b0;
      if (noise) begin
        ct  = rnd192();
        key = rnd192();
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (!busy) ok = 1'b0;
    check("latency", 192'(n), 192'd13);
    check("busy while running", 192'(ok), 192'd1);
    check("pt", pt, p);
    if (hold > 0) begin
      held = pt;
      ok   = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if (pt !== held || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
        @(negedge clk);
      end
      check("hold stable", 192'(ok), 192'd1);
      check("hold pt", pt, p);
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("out_valid after handshake", 192'(out_valid), 192'd0);
    check("in_ready after handshake", 192'(in_ready), 192'd1);
    check("busy after handshake", 192'(busy), 192'd0);
  endtask

  initial begin
    int acc, prev;
    logic ok;

    vecs[0] = '{key: '0, pt: '0};
    vecs[1] = '{key: '1, pt: '1};
    vecs[2] = '{key: '0, pt: 192'd1};
    vecs[3] = '{key: {6{32'hA5A55A5A}}, pt: {6{32'h01234567}}};
    vecs[4] = '{key: {1'b1, 191'd0}, pt: '0};
    vecs[5] = '{key: {24{8'h3C}}, pt: {24{8'hC3}}};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ct = '0; key = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", 192'(in_ready), 192'd1);
    check("reset busy", 192'(busy), 192'd0);
    check("reset out_valid", 192'(out_valid), 192'd0);
    check("reset pt", pt, '0);

    // Reset wins over in_valid in IDLE.
    rst = 1'b1; in_valid = 1'b1; ct = '1; key = '1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("rst over in_valid busy", 192'(busy), 192'd0);
    check("rst over in_valid in_ready", 192'(in_ready), 192'd1);

    // Table-driven directed vectors, consumer always ready.
    for (int i = 0; i < 6; i++) run_block(vecs[i].pt, vecs[i].key, 0, 1'b0, acc);

    // Consumer stalls for 20 cycles.
    run_block(vecs[3].pt, vecs[3].key, 20, 1'b0, acc);

    // in_valid held with changing inputs while busy.
    run_block(vecs[5].pt, vecs[5].key, 0, 1'b1, acc);

    // Abort with reset 8 cycles after accept.
    out_ready = 1'b1;
    ct = encrypt(vecs[3].pt, vecs[3].key); key = vecs[3].key; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("abort in_ready", 192'(in_ready), 192'd1);
    check("abort busy", 192'(busy), 192'd0);
    check("abort pt", pt, '0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) ok = 1'b0;
      @(negedge clk);
    end
    check("abort no out_valid", 192'(ok), 192'd1);
    run_block(vecs[2].pt, vecs[3].key, 0, 1'b0, acc);

    // Back-to-back random blocks, accepts 14 cycles apart.
    prev = 0;
    for (int i = 0; i < 100; i++) begin
      logic [191:0] p, k;
      p = rnd192();
      k = rnd192();
      run_block(p, k, 0, 1'b0, acc);
      if (i > 0) check("accept spacing", 192'(acc - prev), 192'd14);
      prev = acc;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/speedy_dec_iter.md
SPEEDY_DEC_ITER -- requirements
Module: speedy_dec_iter

Interface
REQ-001 The block SHALL run on one clock, with a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 in_valid  input  1  ct and key are valid this cycle.
REQ-005 in_ready  output  1  block can accept a block.
REQ-006 ct  input  192  ciphertext, captured on accept.
REQ-007 key  input  192  master key K, captured on accept.
REQ-008 out_valid  output  1  pt holds a result.
REQ-009 out_ready  input  1  consumer takes pt this cycle.
REQ-010 pt  output  192  recovered plaintext.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL compute pt such that Speedy-6-192 encryption (6 rounds, 192-bit state and key) of pt under key returns ct; the block is the iterative inverse of the team's encryption datapath.
REQ-013 The key schedule SHALL use the existing bit permutation PB: rk0 = K and rk(i+1) = PB(rk(i)); the block SHALL contain PB and its inverse PBinv.
REQ-014 Round constant i (i=0..4) SHALL be XORed with rk(i+1): key bit j is XORed with bit 192*i+j of the hex fraction of pi (243F6A88...), where string bit 0 is the MSB of the leading hex digit.
REQ-015 The FSM SHALL have the states IDLE, KEY, LAST, ROUND and DONE, with a 3-bit counter cnt.
REQ-016 IDLE: in_ready=1; in_valid&&in_ready registers st=ct, rkreg=key, cnt=0, and moves to KEY.
REQ-017 KEY: each cycle sets rkreg=PB(rkreg) and cnt+1; after 6 cycles (rkreg=rk6) the FSM moves to LAST.
REQ-018 LAST (one cycle): st = InvSB(InvSC(InvSB(InvSC(st ^ rk6)))); rkreg=PBinv(rkreg); cnt=4; then ROUND.
REQ-019 ROUND (cnt=4 down to 0, one cycle each): st = InvSB(InvSC(InvSB(InvSC(InvMC(st ^ rkreg ^ RC[cnt]))))); rkreg=PBinv(rkreg); when cnt=0 the FSM moves to DONE, otherwise cnt-1.
REQ-020 On entry to DONE, pt SHALL be registered as st ^ rkreg (rkreg = rk0) and out_valid SHALL be 1.
REQ-021 Latency: out_valid SHALL rise exactly 13 cycles after the accepting edge.
REQ-022 DONE: pt and out_valid SHALL hold stable until out_valid&&out_ready; at that edge out_valid=0 and the FSM moves to IDLE.
REQ-023 in_ready SHALL be 0 in KEY, LAST, ROUND and DONE, so input and output never overlap; the next accept is possible at the earliest one cycle after the output handshake.
REQ-024 in_valid in any non-IDLE state SHALL be ignored, and ct/key changes after accept SHALL not affect the result.
REQ-025 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-026 Throughput SHALL be one block per 14 cycles minimum with out_ready tied high.

Reset
REQ-027 rst at any clock edge SHALL force IDLE, cnt=0, st=0, rkreg=0, pt=0, out_valid=0 and busy=0; in_ready SHALL be 1 in the following cycle.
REQ-028 rst mid-operation SHALL abort the block silently, with no out_valid pulse for it.
REQ-029 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-030 ct = golden-model encryption of pt=192'h0 under K=192'h0, with out_ready=1 -> out_valid rises 13 cycles after accept with pt=192'h0; busy is high for those 13 cycles.
REQ-031 100 random (pt,K) pairs are encrypted by the golden model and decrypted back-to-back with out_ready=1 -> each pt matches, and accepts are spaced exactly 14 cycles apart.
REQ-032 out_ready is held 0 for 20 cycles after out_valid -> pt is stable, in_ready=0 throughout; then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 next cycle.
REQ-033 rst is asserted at cycle 8 after an accept -> no out_valid and pt=0; a fresh block accepted afterwards decrypts correctly.
REQ-034 in_valid is held high with changing ct/key during busy -> ignored; the result matches the originally accepted block.
REQ-035 K=192'hFFFF...FF with ct being the encryption of pt=192'hFFFF...FF -> pt=192'hFFFF...FF, which exercises PB/PBinv over all bits and the constant alignment.
